// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture command arbiter: FSM encodings,
// command indices and the command code width.
package gesture_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_SEND     = 2'd1,
    ARB_COOLDOWN = 2'd2
  } arb_state_e;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_ON  = 4'd0;
  localparam logic [CMD_W-1:0] CMD_OFF = 4'd1;

endpackage

// File: rtl/gesture_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector over the motion requesters 2..N_REQ-1,
// starting just after rr_last and wrapping from N_REQ-1 back to 2.
module rr_pick
  import gesture_pkg::*;
#(
  parameter int N_REQ = 6
) (
  input  logic [N_REQ-1:0] req,
  input  logic [CMD_W-1:0] rr_last,
  output logic             found,
  output logic [CMD_W-1:0] idx
);

  localparam int N_M = N_REQ - 2;

  logic [15:0]      req_pad;
  logic [CMD_W-1:0] cand;
  int               base;

  always_comb begin
    req_pad = 16'(req);
    // base is rr_last expressed as an offset within the motion range
    base    = (int'(rr_last) >= 2) ? int'(rr_last) - 2 : N_M - 1;
    found   = 1'b0;
    idx     = '0;
    cand    = '0;
    for (int k = 1; k <= N_M; k++) begin
      cand = CMD_W'((base + k) % N_M + 2);
      if (!found && req_pad[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gesture_cmd_arbiter.sv
// Arbitrates gesture detector requests into one drone command at a time,
// tracking armed state, enforcing a post-command cooldown and clearing detectors.
module gesture_cmd_arbiter
  import gesture_pkg::*;
#(
  parameter int N_REQ    = 6,
  parameter int COOLDOWN = 16,
  parameter int CD_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             tx_ready,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_code,
  output logic [N_REQ-1:0] det_reset,
  output logic             armed,
  output logic [1:0]       arb_state
);

  localparam logic [CD_W-1:0]  CD_LOAD = (COOLDOWN == 0) ? '0 : CD_W'(COOLDOWN - 1);
  localparam logic [CMD_W-1:0] RR_INIT = CMD_W'(N_REQ - 1);

  // Handshake: cmd_valid/cmd_code stay stable while cmd_valid=1; a transfer
  // happens on the edge where tx_ready=1 is sampled together with cmd_valid=1.
  arb_state_e       state_q, state_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0] cmd_code_q, cmd_code_d;
  logic [N_REQ-1:0] det_reset_q, det_reset_d;
  logic             armed_q, armed_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [CMD_W-1:0] rr_last_q, rr_last_d;

  logic             rr_found;
  logic [CMD_W-1:0] rr_idx;
  logic             grant;
  logic [CMD_W-1:0] grant_idx;
  logic [15:0]      grant_oh;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .found   (rr_found),
    .idx     (rr_idx)
  );

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    det_reset_d = '0;
    armed_d     = armed_q;
    cd_d        = cd_q;
    rr_last_d   = rr_last_q;
    grant       = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;

    case (state_q)
      ARB_IDLE: begin
        if (!armed_q) begin
          // Everything pending while disarmed is flushed; only ON may win.
          det_reset_d = req;
          if (req[0]) begin
            grant     = 1'b1;
            grant_idx = CMD_ON;
          end
        end else begin
          det_reset_d = {{(N_REQ-1){1'b0}}, req[0]};
          if (req[1]) begin
            grant     = 1'b1;
            grant_idx = CMD_OFF;
          end else if (rr_found) begin
            grant     = 1'b1;
            grant_idx = rr_idx;
            rr_last_d = rr_idx;
          end
        end
      end
      ARB_SEND: begin
        if (tx_ready && cmd_valid_q) begin
          cmd_valid_d = 1'b0;
          if (cmd_code_q == CMD_ON)  armed_d = 1'b1;
          if (cmd_code_q == CMD_OFF) armed_d = 1'b0;
          if (COOLDOWN == 0) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_COOLDOWN;
            cd_d    = CD_LOAD;
          end
        end
      end
      ARB_COOLDOWN: begin
        if (cd_q == '0) state_d = ARB_IDLE;
        else            cd_d    = cd_q - CD_W'(1);
      end
      default: state_d = ARB_IDLE;
    endcase

    grant_oh = 16'd1 << grant_idx;
    if (grant) begin
      state_d     = ARB_SEND;
      cmd_valid_d = 1'b1;
      cmd_code_d  = grant_idx;
      det_reset_d = det_reset_d | grant_oh[N_REQ-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      det_reset_q <= '0;
      armed_q     <= 1'b0;
      cd_q        <= '0;
      rr_last_q   <= RR_INIT;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      det_reset_q <= det_reset_d;
      armed_q     <= armed_d;
      cd_q        <= cd_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign det_reset = det_reset_q;
  assign armed     = armed_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_gesture_cmd_arbiter.sv
// Directed bench for gesture_cmd_arbiter: a vector table for the opening
// cycles plus hand-written sequences for cooldown, round-robin, stall and reset.
module tb_gesture_cmd_arbiter;

  localparam int N_REQ = 6;

  logic             clock;
  logic             reset;
  logic [N_REQ-1:0] req;
  logic             tx_ready;
  logic             cmd_valid;
  logic [3:0]       cmd_code;
  logic [N_REQ-1:0] det_reset;
  logic             armed;
  logic [1:0]       arb_state;

  int total;
  int bad;
  logic [3:0] exp_q[$];

  gesture_cmd_arbiter #(.N_REQ(N_REQ), .COOLDOWN(16), .CD_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .tx_ready  (tx_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .det_reset (det_reset),
    .armed     (armed),
    .arb_state (arb_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N_REQ-1:0] req;
    logic             tx;
    logic             exp_valid;
    logic [3:0]       exp_code;
    logic [N_REQ-1:0] exp_det;
    logic             exp_armed;
    logic [1:0]       exp_state;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'(0));
    chk({tag, "_code"},  32'(cmd_code),  32'(0));
    chk({tag, "_det"},   32'(det_reset), 32'(0));
    chk({tag, "_armed"}, 32'(armed),     32'(0));
    chk({tag, "_state"}, 32'(arb_state), 32'(0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (arb_state != 2'd0 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(arb_state), 32'(0));
  endtask

  // Scoreboard: each transfer (valid && ready, not in reset) must match the next expected code.
  always @(negedge clock) begin
    if (!reset && cmd_valid && tx_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL xfer_unexpected: got code %0d want no transfer at %0t", cmd_code, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (cmd_code !== e) begin
          bad++;
          $display("FAIL xfer_code: got %0d want %0d at %0t", cmd_code, e, $time);
        end
      end
    end
  end

  initial begin
    logic [3:0]       rr_exp[5];
    logic [N_REQ-1:0] oh;
    int               gap;

    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    req      = '0;
    tx_ready = 1'b0;
    rr_exp   = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2};

    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    // Disarmed stale-gesture flush, then ON grant and its transfer.
    for (int i = 0; i < 5; i++)
      vecs[i] = '{6'b000100, 1'b0, 1'b0, 4'd0, 6'b000100, 1'b0, 2'd0};
    vecs[5] = '{6'b000000, 1'b0, 1'b0, 4'd0, 6'b000000, 1'b0, 2'd0};
    vecs[6] = '{6'b000001, 1'b1, 1'b1, 4'd0, 6'b000001, 1'b0, 2'd1};
    vecs[7] = '{6'b000000, 1'b1, 1'b0, 4'd0, 6'b000000, 1'b1, 2'd2};
    exp_q.push_back(4'd0);

    for (int i = 0; i < 8; i++) begin
      req      = vecs[i].req;
      tx_ready = vecs[i].tx;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_code", i),  32'(cmd_code),  32'(vecs[i].exp_code));
      chk($sformatf("vec%0d_det", i),   32'(det_reset), 32'(vecs[i].exp_det));
      chk($sformatf("vec%0d_armed", i), 32'(armed),     32'(vecs[i].exp_armed));
      chk($sformatf("vec%0d_state", i), 32'(arb_state), 32'(vecs[i].exp_state));
    end

    // Cooldown: requests held but neither granted nor cleared; IDLE 16 cycles after transfer.
    req = 6'b111100;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("cd_state", 32'(arb_state), 32'(2));
      chk("cd_det",   32'(det_reset), 32'(0));
    end
    tick();
    chk("cd_idle", 32'(arb_state), 32'(0));
    chk("cd_idle_valid", 32'(cmd_valid), 32'(0));

    // Round-robin across motion requesters with wrap; 18 cycles between grants.
    for (int g = 0; g < 5; g++) begin
      exp_q.push_back(rr_exp[g]);
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!cmd_valid && gap < 40);
      oh = 6'(1) << rr_exp[g];
      chk("rr_valid", 32'(cmd_valid), 32'(1));
      chk("rr_code",  32'(cmd_code),  32'(rr_exp[g]));
      chk("rr_det",   32'(det_reset), 32'(oh));
      if (g > 0) chk("rr_gap", 32'(gap), 32'(18));
    end
    req = '0;
    wait_idle();

    // OFF beats a motion request; the motion request is then flushed once disarmed.
    exp_q.push_back(4'd1);
    req = 6'b000110;
    tick();
    chk("off_code",  32'(cmd_code),  32'(1));
    chk("off_det",   32'(det_reset), 32'(6'b000010));
    chk("off_state", 32'(arb_state), 32'(1));
    req = 6'b000100;
    tick();
    chk("off_armed", 32'(armed),     32'(0));
    chk("off_valid", 32'(cmd_valid), 32'(0));
    wait_idle();
    tick();
    chk("flush_det",   32'(det_reset), 32'(6'b000100));
    chk("flush_valid", 32'(cmd_valid), 32'(0));
    chk("flush_state", 32'(arb_state), 32'(0));
    req = '0;
    tick();

    // Stall: tx_ready low for 10 SEND cycles, then one transfer.
    tx_ready = 1'b0;
    exp_q.push_back(4'd0);
    req = 6'b000001;
    tick();
    chk("stall_first", 32'(cmd_valid), 32'(1));
    req = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(cmd_valid), 32'(1));
      chk("stall_code",  32'(cmd_code),  32'(0));
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("stall_done_valid", 32'(cmd_valid), 32'(0));
    chk("stall_done_armed", 32'(armed),     32'(1));
    chk("stall_done_state", 32'(arb_state), 32'(2));

    // Reset during COOLDOWN.
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rst_cd");

    // Reset during SEND, then a normal ON grant.
    req = 6'b000001;
    tick();
    chk("rst_send_pre", 32'(cmd_valid), 32'(1));
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    chk_reset_vals("rst_send");
    exp_q.push_back(4'd0);
    req      = 6'b000001;
    tx_ready = 1'b1;
    tick();
    chk("regrant_valid", 32'(cmd_valid), 32'(1));
    chk("regrant_code",  32'(cmd_code),  32'(0));
    req = '0;
    tick();
    chk("regrant_armed", 32'(armed), 32'(1));
    wait_idle();

    // ON and OFF together: armed picks OFF, disarmed picks ON.
    exp_q.push_back(4'd1);
    req = 6'b000011;
    tick();
    chk("both_armed_code", 32'(cmd_code),  32'(1));
    chk("both_armed_det",  32'(det_reset), 32'(6'b000011));
    req = '0;
    tick();
    chk("both_armed_after", 32'(armed), 32'(0));
    wait_idle();

    exp_q.push_back(4'd0);
    req = 6'b000011;
    tick();
    chk("both_disarmed_code", 32'(cmd_code),  32'(0));
    chk("both_disarmed_det",  32'(det_reset), 32'(6'b000011));
    req = '0;
    tick();
    chk("both_disarmed_after", 32'(armed), 32'(1));
    wait_idle();
    tx_ready = 1'b0;
    tick();

    chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
